// File: rtl/buffer_word_reader_pkg.sv
// Shared state encoding and size derivation for buffer_word_reader.
package buffer_word_reader_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      WAIT_BYTE = 2'b01,
      POP       = 2'b10,
      DONE      = 2'b11
   } state_t;

   function automatic int calc_num_bytes(input int out_len, input int byte_len);
      return out_len / byte_len;
   endfunction

   function automatic int calc_len_w(input int num_bytes);
      return $clog2(num_bytes + 1);
   endfunction

endpackage

// File: rtl/buffer_word_reader_timeout.sv
// Inter-byte timeout counter; only instantiated when BUFFER_WORD_READER_TIMEOUT_EN is defined.
module rd_timeout_counter
   import buffer_word_reader_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 100000,
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
)(
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [CNT_W-1:0] count;

   assign expired = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear || expired) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/buffer_word_reader.sv
// Packs 1..NUM_BYTES UART bytes into one word, LSB- or MSB-first, with abort.
// Optional inter-byte timeout enabled by defining BUFFER_WORD_READER_TIMEOUT_EN.
module buffer_word_reader
   import buffer_word_reader_pkg::*;
#(
   parameter int DATA_LEN       = 8,
   parameter int DATA_OUT_LEN   = 32,
   parameter int TIMEOUT_CYCLES = 100000,
   localparam int NUM_BYTES     = calc_num_bytes(DATA_OUT_LEN, DATA_LEN),
   localparam int LEN_W         = calc_len_w(NUM_BYTES)
)(
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic                    i_rd,
   input  logic [LEN_W-1:0]        i_rd_len,
   input  logic                    i_msb_first,
   input  logic                    i_abort,
   input  logic                    i_is_uart_empty,
   input  logic [DATA_LEN-1:0]     i_uart_data,
   output logic                    o_uart_rd,
   output logic                    o_rd_finished,
   output logic                    o_timeout,
   output logic                    o_busy,
   output logic [LEN_W-1:0]        o_byte_count,
   output logic [DATA_OUT_LEN-1:0] o_rd_buffer
);

   state_t                  state, state_next;
   logic [LEN_W-1:0]        len, len_next;
   logic [LEN_W-1:0]        ptr_next;
   logic [LEN_W-1:0]        slot;
   logic                    msb, msb_next;
   logic [DATA_OUT_LEN-1:0] buffer_next;
   logic                    uart_rd_next;
   logic                    finished_next;

`ifdef BUFFER_WORD_READER_TIMEOUT_EN
   logic expired;
   logic timeout_next;

   rd_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (i_clk),
      .rst_n  (i_reset_n),
      .clear  (state != WAIT_BYTE),
      .enable ((state == WAIT_BYTE) && i_is_uart_empty && (o_byte_count != len)),
      .expired(expired)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_timeout <= 1'b0;
      end else begin
         o_timeout <= timeout_next;
      end
   end
`else
   assign o_timeout = 1'b0;
`endif

   // o_byte_count doubles as the byte pointer and o_rd_buffer as the buffer
   always_comb begin
      state_next    = state;
      len_next      = len;
      msb_next      = msb;
      ptr_next      = o_byte_count;
      buffer_next   = o_rd_buffer;
      uart_rd_next  = 1'b0;
      finished_next = 1'b0;
`ifdef BUFFER_WORD_READER_TIMEOUT_EN
      timeout_next  = 1'b0;
`endif
      slot = msb ? (len - LEN_W'(1) - o_byte_count) : o_byte_count;

      if ((state != IDLE) && i_abort) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (i_rd) begin
                  if ((i_rd_len == '0) || (i_rd_len > LEN_W'(NUM_BYTES))) begin
                     len_next = LEN_W'(NUM_BYTES);
                  end else begin
                     len_next = i_rd_len;
                  end
                  msb_next    = i_msb_first;
                  buffer_next = '0;
                  ptr_next    = '0;
                  state_next  = WAIT_BYTE;
               end
            end
            WAIT_BYTE: begin
               if (o_byte_count == len) begin
                  state_next    = DONE;
                  finished_next = 1'b1;
               end else if (!i_is_uart_empty) begin
                  for (int k = 0; k < NUM_BYTES; k++) begin
                     if (slot == LEN_W'(k)) begin
                        buffer_next[k*DATA_LEN +: DATA_LEN] = i_uart_data;
                     end
                  end
                  uart_rd_next = 1'b1;
                  state_next   = POP;
               end
`ifdef BUFFER_WORD_READER_TIMEOUT_EN
               else if (expired) begin
                  state_next   = IDLE;
                  timeout_next = 1'b1;
               end
`endif
            end
            POP: begin
               ptr_next   = o_byte_count + LEN_W'(1);
               state_next = WAIT_BYTE;
            end
            DONE: begin
               state_next = IDLE;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state         <= IDLE;
         len           <= '0;
         msb           <= 1'b0;
         o_byte_count  <= '0;
         o_rd_buffer   <= '0;
         o_uart_rd     <= 1'b0;
         o_rd_finished <= 1'b0;
         o_busy        <= 1'b0;
      end else begin
         state         <= state_next;
         len           <= len_next;
         msb           <= msb_next;
         o_byte_count  <= ptr_next;
         o_rd_buffer   <= buffer_next;
         o_uart_rd     <= uart_rd_next;
         o_rd_finished <= finished_next;
         o_busy        <= (state_next != IDLE);
      end
   end

endmodule

// File: tb/tb_buffer_word_reader.sv
// Directed bench for buffer_word_reader with a small queue-based RX FIFO model.
module tb_buffer_word_reader;

   localparam int LEN_W = 3;

   logic        clk = 1'b0;
   logic        i_reset_n;
   logic        i_rd;
   logic [2:0]  i_rd_len;
   logic        i_msb_first;
   logic        i_abort;
   logic        i_is_uart_empty;
   logic [7:0]  i_uart_data;
   logic        o_uart_rd;
   logic        o_rd_finished;
   logic        o_timeout;
   logic        o_busy;
   logic [2:0]  o_byte_count;
   logic [31:0] o_rd_buffer;

   int          checks = 0;
   int          errors = 0;
   int          edge_no;
   int          uart_pulses;
   int          fin_pulses;
   int          fin_edge;
   int          to_pulses;
   int          busy_low;
   int          n;
   logic [31:0] pop_mask;
   logic [7:0]  fifo[$];
   logic [7:0]  junk;

   buffer_word_reader #(
      .DATA_LEN(8),
      .DATA_OUT_LEN(32),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .i_clk          (clk),
      .i_reset_n      (i_reset_n),
      .i_rd           (i_rd),
      .i_rd_len       (i_rd_len),
      .i_msb_first    (i_msb_first),
      .i_abort        (i_abort),
      .i_is_uart_empty(i_is_uart_empty),
      .i_uart_data    (i_uart_data),
      .o_uart_rd      (o_uart_rd),
      .o_rd_finished  (o_rd_finished),
      .o_timeout      (o_timeout),
      .o_busy         (o_busy),
      .o_byte_count   (o_byte_count),
      .o_rd_buffer    (o_rd_buffer)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_fifo();
      i_is_uart_empty = (fifo.size() == 0);
      i_uart_data     = (fifo.size() != 0) ? fifo[0] : 8'h00;
   endtask

   // one clock; observe at the falling edge, then re-drive the FIFO head
   task automatic tick();
      @(negedge clk);
      edge_no++;
      if (o_uart_rd) begin
         uart_pulses++;
         if (edge_no >= 0 && edge_no < 32) pop_mask[edge_no] = 1'b1;
         if (fifo.size() != 0) junk = fifo.pop_front();
      end
      if (o_rd_finished) begin
         fin_pulses++;
         fin_edge = edge_no;
      end
      if (o_timeout) to_pulses++;
      drive_fifo();
   endtask

   task automatic start(input logic [2:0] len, input logic msb);
      pop_mask    = '0;
      uart_pulses = 0;
      fin_pulses  = 0;
      fin_edge    = -1;
      to_pulses   = 0;
      busy_low    = 0;
      edge_no     = -1;
      i_rd        = 1'b1;
      i_rd_len    = len;
      i_msb_first = msb;
      tick();
      i_rd        = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int maxc);
      int c;
      c = 0;
      while (o_busy && c < maxc) begin
         tick();
         c++;
      end
      chk({tag, "_idle"}, 64'(o_busy), 64'd0);
   endtask

   initial begin
      i_reset_n = 1'b0;
      i_rd = 1'b0;
      i_rd_len = '0;
      i_msb_first = 1'b0;
      i_abort = 1'b0;
      drive_fifo();
      edge_no = 0;
      #12;
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_buf", 64'(o_rd_buffer), 64'd0);
      chk("rst_cnt", 64'(o_byte_count), 64'd0);
      chk("rst_pulses", 64'({o_uart_rd, o_rd_finished, o_timeout}), 64'd0);
      @(negedge clk);
      i_reset_n = 1'b1;
      tick();

      // len=4, LSB-first, data always available
      fifo = '{8'h11, 8'h22, 8'h33, 8'h44};
      drive_fifo();
      start(3'd4, 1'b0);
      wait_idle("t1", 40);
      chk("t1_buf", 64'(o_rd_buffer), 64'h44332211);
      chk("t1_pop_edges", 64'(pop_mask), 64'h000000AA);
      chk("t1_fin_edge", 64'(fin_edge), 64'd9);
      chk("t1_fin_pulses", 64'(fin_pulses), 64'd1);
      chk("t1_cnt", 64'(o_byte_count), 64'd4);
      tick(); tick();
      chk("t1_hold", 64'(o_rd_buffer), 64'h44332211);

      // len=3, MSB-first
      fifo = '{8'hAA, 8'hBB, 8'hCC};
      drive_fifo();
      start(3'd3, 1'b1);
      wait_idle("t2", 40);
      chk("t2_buf", 64'(o_rd_buffer), 64'h00AABBCC);
      chk("t2_cnt", 64'(o_byte_count), 64'd3);

      // len=0 saturates to 4
      fifo = '{8'h01, 8'h02, 8'h03, 8'h04};
      drive_fifo();
      start(3'd0, 1'b0);
      wait_idle("t2z", 40);
      chk("t2z_buf", 64'(o_rd_buffer), 64'h04030201);
      chk("t2z_cnt", 64'(o_byte_count), 64'd4);

      // len=7 saturates to 4, MSB-first; fifth byte left in FIFO
      fifo = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
      drive_fifo();
      start(3'd7, 1'b1);
      wait_idle("t2s", 40);
      chk("t2s_buf", 64'(o_rd_buffer), 64'h10203040);
      chk("t2s_left", 64'(fifo.size()), 64'd1);
      fifo.delete();
      drive_fifo();

      // FIFO empty for 5 cycles between bytes 2 and 3
      fifo = '{8'hDE, 8'hAD};
      drive_fifo();
      start(3'd4, 1'b0);
      n = 0;
      while (uart_pulses < 2 && n < 20) begin tick(); n++; end
      for (int i = 0; i < 5; i++) begin
         tick();
         if (!o_busy) busy_low++;
      end
      chk("t3_gap_pops", 64'(uart_pulses), 64'd2);
      fifo.push_back(8'hBE);
      fifo.push_back(8'hEF);
      drive_fifo();
      n = 0;
      while (fin_pulses == 0 && n < 30) begin
         tick();
         if (!o_busy) busy_low++;
         n++;
      end
      wait_idle("t3", 10);
      chk("t3_buf", 64'(o_rd_buffer), 64'hEFBEADDE);
      chk("t3_pops", 64'(uart_pulses), 64'd4);
      chk("t3_busy_low", 64'(busy_low), 64'd0);

      // abort in the same cycle the 2nd byte becomes available
      fifo = '{8'h5A};
      drive_fifo();
      start(3'd4, 1'b0);
      n = 0;
      while (uart_pulses < 1 && n < 10) begin tick(); n++; end
      tick();
      fifo.push_back(8'h6B);
      drive_fifo();
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      chk("t4_uart_rd", 64'(o_uart_rd), 64'd0);
      chk("t4_busy", 64'(o_busy), 64'd0);
      chk("t4_cnt", 64'(o_byte_count), 64'd1);
      chk("t4_buf", 64'(o_rd_buffer), 64'h0000005A);
      chk("t4_fifo", 64'(fifo.size()), 64'd1);
      tick(); tick();
      chk("t4_fin", 64'(fin_pulses), 64'd0);
      fifo.push_back(8'h01);
      fifo.push_back(8'h02);
      fifo.push_back(8'h03);
      drive_fifo();
      start(3'd4, 1'b0);
      wait_idle("t4b", 40);
      chk("t4b_buf", 64'(o_rd_buffer), 64'h0302016B);
      chk("t4b_fin", 64'(fin_pulses), 64'd1);

      // i_rd while busy is ignored
      fifo = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
      drive_fifo();
      start(3'd4, 1'b0);
      tick();
      i_rd = 1'b1;
      i_rd_len = 3'd1;
      tick(); tick();
      i_rd = 1'b0;
      wait_idle("t5", 40);
      chk("t5_buf", 64'(o_rd_buffer), 64'hA4A3A2A1);
      chk("t5_left", 64'(fifo.size()), 64'd4);
      tick(); tick();
      chk("t5_fin", 64'(fin_pulses), 64'd1);

      // asynchronous reset mid-read
      start(3'd4, 1'b0);
      tick();
      #2 i_reset_n = 1'b0;
      #1;
      chk("t5r_busy", 64'(o_busy), 64'd0);
      chk("t5r_uart_rd", 64'(o_uart_rd), 64'd0);
      chk("t5r_buf", 64'(o_rd_buffer), 64'd0);
      chk("t5r_cnt", 64'(o_byte_count), 64'd0);
      @(negedge clk);
      i_reset_n = 1'b1;
      fifo.delete();
      drive_fifo();
      fin_pulses = 0;
      tick(); tick();
      chk("t5r_nofin", 64'(fin_pulses), 64'd0);

      // FIFO runs dry after one byte
      fifo = '{8'hC7};
      drive_fifo();
      start(3'd4, 1'b0);
      n = 0;
      while (uart_pulses < 1 && n < 10) begin tick(); n++; end
      tick();
`ifdef BUFFER_WORD_READER_TIMEOUT_EN
      n = 0;
      while (to_pulses == 0 && n < 40) begin tick(); n++; end
      chk("t6_to_delay", 64'(n), 64'd16);
      tick(); tick();
      chk("t6_to_pulses", 64'(to_pulses), 64'd1);
      chk("t6_busy", 64'(o_busy), 64'd0);
`else
      for (int i = 0; i < 40; i++) tick();
      chk("t6_to_pulses", 64'(to_pulses), 64'd0);
      chk("t6_busy", 64'(o_busy), 64'd1);
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      chk("t6_abort_busy", 64'(o_busy), 64'd0);
`endif
      chk("t6_cnt", 64'(o_byte_count), 64'd1);
      chk("t6_buf", 64'(o_rd_buffer), 64'h000000C7);
      chk("t6_fin", 64'(fin_pulses), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
